// File: rtl/axi_mgr_rd.sv
// Single-outstanding AXI4 read manager: one client burst -> AR, R beats streamed back, one completion.
// Optional exclusive-access support is enabled by defining AXI_MGR_RD_EXCL_EN.
module axi_mgr_rd #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 3,
    parameter int unsigned UW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_len,
    input  logic [2:0]    req_size,
    input  logic [1:0]    req_burst,
    input  logic [IW-1:0] req_id,
    input  logic [UW-1:0] req_user,
`ifdef AXI_MGR_RD_EXCL_EN
    input  logic          req_lock,
`endif
    output logic [AW-1:0] m_araddr,
    output logic [1:0]    m_arburst,
    output logic [2:0]    m_arsize,
    output logic [7:0]    m_arlen,
    output logic [UW-1:0] m_aruser,
    output logic [IW-1:0] m_arid,
    output logic          m_arlock,
    output logic          m_arvalid,
    input  logic          m_arready,
    input  logic [DW-1:0] m_rdata,
    input  logic [1:0]    m_rresp,
    input  logic [IW-1:0] m_rid,
    input  logic [UW-1:0] m_ruser,
    input  logic          m_rlast,
    input  logic          m_rvalid,
    output logic          m_rready,
    output logic          data_valid,
    input  logic          data_ready,
    output logic [DW-1:0] data,
    output logic          data_last,
    output logic          done_valid,
    output logic [1:0]    done_resp,
    output logic          done_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
`ifdef AXI_MGR_RD_EXCL_EN
        logic          lock;
`endif
    } axi_ctx_t;

    logic [2:0] state_q, state_d;
    axi_ctx_t   ctx_q, ctx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] resp_q, resp_d;
    logic       err_q, err_d;
    logic       beat;
    logic       last_beat;
    logic       excl_fail;
    logic       unused_ruser;

    assign unused_ruser = ^m_ruser;

    assign beat      = m_rvalid & m_rready;
    assign last_beat = (cnt_q == ctx_q.len);

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    ctx_d.addr  = req_addr;
                    ctx_d.len   = req_len;
                    ctx_d.size  = req_size;
                    ctx_d.burst = req_burst;
                    ctx_d.id    = req_id;
                    ctx_d.user  = req_user;
`ifdef AXI_MGR_RD_EXCL_EN
                    ctx_d.lock  = req_lock;
`endif
                    cnt_d   = '0;
                    resp_d  = RESP_OKAY;
                    err_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_arready) state_d = S_DATA;
            end
            S_DATA: begin
                if (beat) begin
                    cnt_d = cnt_q + 8'd1;
                    // SLVERR/DECERR is sticky; EXOKAY survives only if every beat is EXOKAY
                    if (resp_q[1])                                         resp_d = resp_q;
                    else if (m_rresp[1] || cnt_q == 8'd0)                  resp_d = m_rresp;
                    else if (resp_q == RESP_EXOKAY && m_rresp == RESP_EXOKAY) resp_d = RESP_EXOKAY;
                    else                                                    resp_d = RESP_OKAY;
                    if (m_rid != ctx_q.id) err_d = 1'b1;
                    if (last_beat) begin
                        if (m_rlast) begin
                            state_d = S_DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else if (m_rlast) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (beat && m_rlast) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctx_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

`ifdef AXI_MGR_RD_EXCL_EN
    assign m_arlock  = ctx_q.lock;
    assign excl_fail = ctx_q.lock & (resp_q == RESP_OKAY);
`else
    assign m_arlock  = 1'b0;
    assign excl_fail = 1'b0;
`endif

    assign req_ready  = (state_q == S_IDLE);
    assign m_arvalid  = (state_q == S_ADDR);
    assign m_araddr   = ctx_q.addr;
    assign m_arburst  = ctx_q.burst;
    assign m_arsize   = ctx_q.size;
    assign m_arlen    = ctx_q.len;
    assign m_aruser   = ctx_q.user;
    assign m_arid     = ctx_q.id;

    // Client path is a zero-latency pass-through of R while in DATA
    assign data_valid = (state_q == S_DATA) & m_rvalid;
    assign m_rready   = ((state_q == S_DATA) & data_ready) | (state_q == S_DRAIN);
    assign data       = m_rdata;
    assign data_last  = (state_q == S_DATA) & last_beat;

    assign done_valid = (state_q == S_DONE);
    assign done_resp  = resp_q;
    assign done_err   = (state_q == S_DONE) & (err_q | excl_fail);

endmodule

// File: doc/axi_mgr_rd.md
Name: axi_mgr_rd

Overview:
- Single-outstanding AXI4 read manager (initiator). Counterpart to the subordinate-side read path.
- Accepts one burst request from a local client, issues it on AR, streams R beats back to the client with backpressure, and reports one completion status per burst.
- Used by DMA-style engines that need to pull data from an AXI fabric using the shared axi_pkg types (axi_burst_e, axi_resp_e).

Parameters:
- AW, 32, address width (matches axi_pkg::AW)
- DW, 32, data width; must be 32 or 64
- IW, 3, ID width (matches axi_pkg::IW)
- UW, 32, user width (matches axi_pkg::UW)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  burst request valid
- req_ready  out  1  request accepted when high with req_valid
- req_addr  in  AW  start address
- req_len  in  8  beats minus 1
- req_size  in  3  log2 bytes per beat; must be ≤ log2(DW/8)
- req_burst  in  2  axi_burst_e
- req_id  in  IW  transaction ID
- req_user  in  UW  user sideband
- m_araddr/arburst/arsize/arlen/aruser/arid  out  AW/2/3/8/UW/IW  AR payload
- m_arlock  out  1  exclusive access indicator
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rdata/rresp/rid/ruser/rlast  in  DW/2/IW/UW/1  R payload
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- data_valid  out  1  beat to client valid
- data_ready  in  1  client accepts beat
- data  out  DW  beat data
- data_last  out  1  final beat of burst
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  aggregated axi_resp_e
- done_err  out  1  protocol error (ID mismatch or rlast misplacement)

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. Reset values: FSM=IDLE; req_ready=1; m_arvalid, m_rready, data_valid, data_last, done_valid, done_err = 0; done_resp=OKAY; AR payload registers = 0.
- FSM states: IDLE, ADDR, DATA, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, register all request fields into an axi_ctx_t and go to ADDR.
  - Clear beat counter, resp accumulator and error flag.
- ADDR:
  - m_arvalid=1 with registered payload, held stable until m_arready.
  - arvalid asserts the cycle after request acceptance (1-cycle latency).
  - On m_arready, go to DATA.
- DATA:
  - data_valid = m_rvalid; m_rready = data_ready (combinational pass-through, zero latency).
  - data = m_rdata; data_last = (cnt == len).
  - A beat transfers when m_rvalid & m_rready; cnt increments on each beat.
- Per-beat response aggregation:
  - SLVERR/DECERR: the first such code is captured sticky.
  - Otherwise EXOKAY is kept only while every beat returns EXOKAY; any OKAY beat demotes the result to OKAY.
- Per-beat error checks:
  - rid ≠ registered id sets err.
  - rlast=1 with cnt<len sets err and moves to DONE (burst truncated; data_last was 0 on that beat).
  - cnt==len with rlast=0 sets err and moves to DRAIN.
  - Normal end (cnt==len, rlast=1) moves to DONE.
- DRAIN:
  - data_valid=0, m_rready=1; surplus beats are discarded.
  - Go to DONE on a beat with rlast=1.
- DONE:
  - done_valid=1 for exactly one cycle, with done_resp/done_err valid; then return to IDLE.
  - req_ready is 0 in DONE; a new request is accepted no earlier than the following cycle.
- Counter: 8-bit; len=255 gives 256 beats with no wrap issue, because termination is compared against len before increment.
- Reset mid-burst aborts immediately to IDLE with no completion pulse; the fabric-side effects are the system's responsibility.
- Address arithmetic is not performed locally; burst addressing belongs to the subordinate. req_burst=RESERVED is forwarded unchanged.

Optional Feature:
- Macro: AXI_MGR_RD_EXCL_EN.
- Defined:
  - Adds input port req_lock (1 bit), registered with the request and driven on m_arlock.
  - For locked bursts, a final done_resp of OKAY (not EXOKAY) also sets done_err, flagging a failed exclusive read.
- Undefined: no req_lock port; m_arlock is tied 0; EXOKAY responses are still aggregated but never cause an error.

Test Plan:
- Single beat: addr=0x1000, len=0, size=2, INCR, id=3, arready delayed 2 cycles → arvalid held 3 cycles with stable payload; one beat 0xA5A5A5A5 with data_last=1; done_valid 1 cycle later, resp=OKAY, err=0.
- Backpressure: len=7, data_ready toggled every cycle → exactly 8 beats delivered in order, m_rready mirrors data_ready, data_last only on beat 7.
- Error aggregation: len=3, rresp OKAY, SLVERR, DECERR, OKAY → done_resp=SLVERR, done_err=0.
- Early rlast: len=3, rlast on beat 1 → 2 beats delivered, data_last never asserted, done_err=1, return to IDLE.
- Late rlast: len=1, subordinate sends 4 beats → client sees 2, remaining 2 drained with data_valid=0, done_err=1 after 4th beat; id mismatch on any beat → done_err=1.
- Reset mid-burst: rst_n low during DATA beat 2 of len=15 → all outputs go to reset values immediately, no done_valid; a subsequent request completes normally. With AXI_MGR_RD_EXCL_EN: req_lock=1, all beats OKAY → m_arlock=1, done_err=1.
